// File: rtl/alu_arbiter_if.sv
// Purpose: bus bundle between the two ALU requesters, the alu_arbiter and the
// shared combinational ALU. Per-requester fields are packed {r1,r0}.
//   req_*   : request channel (valid/ready, opcode, operands, imm select)
//   rsp_*   : response channel (one-hot valid, shared data/flags/err)
//   alu_*   : operand/result wiring to the shared ALU
//   busy    : arbiter has an operation in flight
// Modports: slave = arbiter side, master = requesters + ALU side.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_func;
  logic [63:0] req_in1;
  logic [63:0] req_in2;
  logic [63:0] req_imm_in;
  logic [1:0]  req_imm;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_flags;
  logic        rsp_err;
  logic [4:0]  alu_func;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_imm_in;
  logic        alu_imm;
  logic [31:0] alu_outp;
  logic [5:0]  alu_flags;
  logic        busy;

  modport slave (
    input  req_valid, req_func, req_in1, req_in2, req_imm_in, req_imm,
    input  rsp_ready, alu_outp, alu_flags,
    output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err,
    output alu_func, alu_in1, alu_in2, alu_imm_in, alu_imm, busy
  );

  modport master (
    output req_valid, req_func, req_in1, req_in2, req_imm_in, req_imm,
    output rsp_ready, alu_outp, alu_flags,
    input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_err,
    input  alu_func, alu_in1, alu_in2, alu_imm_in, alu_imm, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Purpose: round-robin arbiter sharing one combinational ALU between r0
// (execute stage) and r1 (address/aux unit). One op in flight at a time:
// accept, hold registered operands on alu_* for ALU_WAIT cycles, capture the
// result and flags, then present them on the granted requester's response
// channel until consumed.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : alu_arbiter_if.slave (request, response and ALU wiring, busy)
// Parameter:
//   ALU_WAIT : cycles operands sit on alu_* before capture (1..15)
//
// state | meaning
// IDLE  | waiting for a request; req_ready offered to the granted requester
// ISSUE | operands on alu_*, counting down wait_cnt before result capture
// RESP  | response valid to the granted requester, waiting for rsp_ready
module alu_arbiter #(
  parameter int unsigned ALU_WAIT = 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT - 1);

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        grant_q;
  logic [3:0]  wait_cnt_q;
  logic        grant;
  logic        accept, legal, capture, rsp_done;
  logic [1:0]  req_ready_c;
  logic [4:0]  sel_func;
  logic [31:0] sel_in1, sel_in2, sel_imm_in;
  logic        sel_imm;

  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [5:0]  rsp_flags_q;
  logic        rsp_err_q;
  logic [4:0]  alu_func_q;
  logic [31:0] alu_in1_q, alu_in2_q, alu_imm_in_q;
  logic        alu_imm_q;

  // Grant: sole valid requester wins; on a tie the one not served last wins.
  always_comb begin
    grant = bus.req_valid[1];
    if (bus.req_valid == 2'b11) grant = ~last_grant_q;
    sel_func   = grant ? bus.req_func[9:5]     : bus.req_func[4:0];
    sel_in1    = grant ? bus.req_in1[63:32]    : bus.req_in1[31:0];
    sel_in2    = grant ? bus.req_in2[63:32]    : bus.req_in2[31:0];
    sel_imm_in = grant ? bus.req_imm_in[63:32] : bus.req_imm_in[31:0];
    sel_imm    = grant ? bus.req_imm[1]        : bus.req_imm[0];
    // 5'h09 is a hole in the opcode map; 5'h0F and above are unused.
    legal = (sel_func <= 5'h08) || ((sel_func >= 5'h0A) && (sel_func <= 5'h0E));
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = 2'b00;
    accept      = 1'b0;
    capture     = 1'b0;
    rsp_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = grant ? 2'b10 : 2'b01;
          accept      = 1'b1;
          state_d     = legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        if (wait_cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // Only the granted requester's ready can retire the response.
        if (bus.rsp_ready[grant_q]) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      wait_cnt_q   <= 4'd0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 32'd0;
      rsp_flags_q  <= 6'd0;
      rsp_err_q    <= 1'b0;
      alu_func_q   <= 5'd0;
      alu_in1_q    <= 32'd0;
      alu_in2_q    <= 32'd0;
      alu_imm_in_q <= 32'd0;
      alu_imm_q    <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= grant;
        if (legal) begin
          alu_func_q   <= sel_func;
          alu_in1_q    <= sel_in1;
          alu_in2_q    <= sel_in2;
          alu_imm_in_q <= sel_imm_in;
          alu_imm_q    <= sel_imm;
          wait_cnt_q   <= WAIT_INIT;
        end else begin
          // Illegal op is answered immediately; the ALU never sees it.
          rsp_data_q  <= 32'd0;
          rsp_flags_q <= 6'd0;
          rsp_err_q   <= 1'b1;
          rsp_valid_q <= grant ? 2'b10 : 2'b01;
        end
      end
      if (state_q == ISSUE && !capture) wait_cnt_q <= wait_cnt_q - 4'd1;
      if (capture) begin
        rsp_data_q  <= bus.alu_outp;
        rsp_flags_q <= bus.alu_flags;
        rsp_err_q   <= 1'b0;
        rsp_valid_q <= grant_q ? 2'b10 : 2'b01;
      end
      if (rsp_done) begin
        rsp_valid_q  <= 2'b00;
        last_grant_q <= grant_q;
      end
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.alu_func   = alu_func_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.alu_imm_in = alu_imm_in_q;
  assign bus.alu_imm    = alu_imm_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
